// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data (load/store) port. Data normally has priority; a saturating starvation
//   counter guarantees that a pending fetch wins after STARVE_MAX consecutive
//   data grants. Each access waits for m_rdy, bounded by TIMEOUT cycles; a
//   timed-out access raises err, spends one RECOVER cycle and is dropped.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   hlt                         CPU halted: no new instruction grants
//   i_req/i_addr                fetch request and address
//   i_rdata/i_rdy               fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata   data request, direction, address, store data
//   d_rdata/d_rdy               load data and completion pulse
//   m_en/m_we/m_addr/m_wdata    memory request side
//   m_rdata/m_rdy               memory response side
//   err                         one-cycle access timeout pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hlt,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_rdy,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_rdy,
  output logic        m_en,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_rdy,
  output logic        err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_I_BUSY  = 2'd1;
  localparam logic [1:0] S_D_BUSY  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  // Value the wait counter holds during the last permitted BUSY cycle.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [15:0]   m_addr_q, m_addr_d;
  logic [15:0]   m_wdata_q, m_wdata_d;
  logic          m_we_q, m_we_d;

  logic busy;
  logic inst_ok;
  logic grant_i;
  logic grant_d;
  logic timeout;

  assign busy    = (state_q == S_I_BUSY) || (state_q == S_D_BUSY);
  assign inst_ok = i_req && !hlt;

  // Instruction wins only if data is absent or the data port has used up
  // its run of consecutive grants against a pending fetch.
  assign grant_i = (state_q == S_IDLE) && inst_ok &&
                   (!d_req || (starve_q == STARVE_TOP));
  assign grant_d = (state_q == S_IDLE) && d_req && !grant_i;

  // Fires in the TIMEOUT-th BUSY cycle if memory still has not answered.
  assign timeout = busy && !m_rdy && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = m_we_q;
    case (state_q)
      S_IDLE: begin
        if (!i_req) begin
          starve_d = '0;
        end
        if (grant_i) begin
          state_d  = S_I_BUSY;
          starve_d = '0;
          wait_d   = '0;
          m_addr_d = i_addr;
          m_we_d   = 1'b0;
        end else if (grant_d) begin
          state_d   = S_D_BUSY;
          wait_d    = '0;
          m_addr_d  = d_addr;
          m_we_d    = d_we;
          m_wdata_d = d_wdata;
          if (inst_ok && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      S_I_BUSY, S_D_BUSY: begin
        if (m_rdy) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_RECOVER;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        // RECOVER: single dead cycle after a timeout.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      wait_q    <= '0;
      m_addr_q  <= 16'h0000;
      m_wdata_q <= 16'h0000;
      m_we_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
    end
  end

  // Request-side outputs come straight from state so that an asynchronous
  // reset removes m_en and any rdy pulse without waiting for a clock edge.
  assign m_en    = busy;
  assign m_we    = m_we_q && busy;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign i_rdy   = (state_q == S_I_BUSY) && m_rdy;
  assign d_rdy   = (state_q == S_D_BUSY) && m_rdy;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign err     = timeout;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive data grants while i_req is pending.
REQ-002 Parameter: TIMEOUT, default 255, max cycles to wait for m_rdy per access.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 hlt  in  1  CPU halted; blocks new instruction grants.
REQ-006 i_req  in  1  instruction fetch request; held high until i_rdy.
REQ-007 i_addr  in  16  fetch address (pc); stable while i_req high.
REQ-008 i_rdata  out  16  fetched word; valid only when i_rdy=1.
REQ-009 i_rdy  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data access request; held high until d_rdy.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  16  data address.
REQ-013 d_wdata  in  16  store data.
REQ-014 d_rdata  out  16  load data; valid only when d_rdy=1.
REQ-015 d_rdy  out  1  one-cycle data completion pulse, for loads and stores.
REQ-016 m_en  out  1  memory access active.
REQ-017 m_we  out  1  memory write enable.
REQ-018 m_addr  out  16  memory address.
REQ-019 m_wdata  out  16  memory write data.
REQ-020 m_rdata  in  16  memory read data; valid when m_rdy=1.
REQ-021 m_rdy  in  1  memory completion pulse; arrives 1 or more cycles after m_en rises.
REQ-022 err  out  1  one-cycle timeout pulse.

Function
REQ-023 FSM states: IDLE, I_BUSY, D_BUSY, RECOVER.
- IDLE -> D_BUSY: d_req=1 and grant rule selects data.
- IDLE -> I_BUSY: i_req=1, hlt=0, and grant rule selects instruction.
- Otherwise the FSM stays in IDLE.
REQ-024 Grant rule: data wins over instruction, except when starve_cnt == STARVE_MAX and i_req=1 and hlt=0; instruction then wins.
REQ-025 starve_cnt:
- Increments on each data grant made while i_req=1 and hlt=0, saturating at STARVE_MAX.
- Clears to 0 on any instruction grant, and in any IDLE cycle with i_req=0.
REQ-026 On a grant, the winning port's address, we and wdata are registered into m_addr, m_we and m_wdata.
- m_we is forced to 0 for instruction grants.
- m_en = 1 exactly while the FSM is in I_BUSY or D_BUSY.
REQ-027 In the BUSY state, when m_rdy=1:
- The matching rdy output pulses in the same cycle (combinational, gated by state).
- The matching rdata output equals m_rdata in that cycle.
- The FSM goes to IDLE at the next edge.
REQ-028 Minimum turnaround is one IDLE cycle between accesses: from grant edge to grant edge is at least latency+1 cycles.
REQ-029 m_rdy arriving in IDLE or RECOVER is ignored; neither i_rdy nor d_rdy pulses.
REQ-030 Each BUSY entry clears a wait counter; the counter increments every BUSY cycle without m_rdy.
- On reaching TIMEOUT, err pulses for one cycle and the FSM goes to RECOVER.
- No rdy is issued for a timed-out access.
REQ-031 RECOVER lasts exactly one cycle, then returns to IDLE.
- The timed-out requester, if still requesting, rearbitrates normally.
REQ-032 hlt=1 blocks only new instruction grants.
- An I_BUSY access already in progress completes normally.
- Data requests continue to be served.
REQ-033 A requester dropping req mid-access does not abort it: the access completes and rdy still pulses.
REQ-034 m_wdata and m_addr hold their registered values between accesses.

Reset
REQ-035 While rst_n=0, asynchronously:
- FSM = IDLE; starve_cnt = 0; wait counter = 0.
- m_en, m_we, i_rdy, d_rdy and err = 0.
- m_addr and m_wdata = 16'h0000.
REQ-036 Reset asserted mid-access abandons the access: no rdy pulse, and m_en drops immediately.
REQ-037 After rst_n deasserts, the first grant occurs no earlier than the first rising edge at which rst_n=1.

Verification
REQ-038 Single fetch: i_req=1, i_addr=16'h0010, memory returns 16'hA5A5 with 2-cycle latency -> m_en high 2 cycles, m_addr=16'h0010, m_we=0, i_rdy pulses once with i_rdata=16'hA5A5.
REQ-039 Simultaneous requests: i_req and d_req both rise in the same cycle, d_we=1, d_addr=16'h0100, d_wdata=16'h1234 -> data granted first (m_we=1, m_wdata=16'h1234), then instruction granted after one IDLE cycle.
REQ-040 Starvation: d_req held high continuously with i_req=1, STARVE_MAX=4 -> 4 data grants, then 1 instruction grant, then data resumes.
REQ-041 Timeout: TIMEOUT=8, memory never asserts m_rdy on a load -> err pulses on the 8th BUSY cycle, no d_rdy, RECOVER for 1 cycle, then the held d_req is regranted.
REQ-042 Halt: hlt=1 with i_req=1 and d_req=0 -> m_en stays 0 indefinitely; clearing hlt -> fetch granted on the next edge.
REQ-043 Reset mid-access: rst_n low during D_BUSY -> m_en=0 immediately, no d_rdy; after release, a new request is served normally.
